// File: rtl/usb_endp_pkg.sv
// rtl/usb_endp_pkg.sv - shared constants, encodings and status packing for the endpoint status bank
package usb_endp_pkg;

  localparam int MAX_ENDP = 16;
  localparam int EP_IDX_W = $clog2(MAX_ENDP);
  localparam int STATUS_W = 8;

  localparam int STAT_CRC      = 0;
  localparam int STAT_BITSTUFF = 1;
  localparam int STAT_RXOVF    = 2;
  localparam int STAT_RXTO     = 3;
  localparam int STAT_NAK      = 4;
  localparam int STAT_STALL    = 5;
  localparam int STAT_ACK      = 6;
  localparam int STAT_DSEQ     = 7;

  typedef enum logic [1:0] {
    TT_SETUP   = 2'd0,
    TT_IN      = 2'd1,
    TT_OUTDATA = 2'd2
  } trans_type_e;

  // Completed (non-NAK) transaction word; the NAK bit is always clear here.
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic data_seq,
    input logic ack_rxed,
    input logic stall_sent,
    input logic rx_timeout,
    input logic rx_overflow,
    input logic bit_stuff_err,
    input logic crc_err
  );
    logic [STATUS_W-1:0] w;
    w                = '0;
    w[STAT_DSEQ]     = data_seq;
    w[STAT_ACK]      = ack_rxed;
    w[STAT_STALL]    = stall_sent;
    w[STAT_NAK]      = 1'b0;
    w[STAT_RXTO]     = rx_timeout;
    w[STAT_RXOVF]    = rx_overflow;
    w[STAT_BITSTUFF] = bit_stuff_err;
    w[STAT_CRC]      = crc_err;
    return w;
  endfunction

endpackage

// File: rtl/usb_endp_status_bank_if.sv
// rtl/usb_endp_status_bank_if.sv - transaction-controller / host signal bundle for the endpoint status bank
interface usb_endp_status_bank_if #(
  parameter int NUM_ENDP  = 4,
  parameter int CTRL_W    = 5,
  parameter int NAK_CNT_W = 8
) ();

  logic [usb_endp_pkg::EP_IDX_W-1:0] currEndP;
  logic                              NAKSent;
  logic                              stallSent;
  logic                              CRCError;
  logic                              bitStuffError;
  logic                              RxOverflow;
  logic                              RxTimeOut;
  logic                              dataSequence;
  logic                              ACKRxed;
  logic [1:0]                        transType;
  logic [1:0]                        transTypeNAK;
  logic                              endPMuxErrorsWEn;
  logic                              clrEPRdy;
  logic [NUM_ENDP*CTRL_W-1:0]        endPCtrlFlat;
  logic                              statusClrEn;
  logic [usb_endp_pkg::EP_IDX_W-1:0] statusClrEP;

  logic [CTRL_W-1:0]                 endPControlReg;
  logic [NUM_ENDP-1:0]               clrEPRdyVec;
  logic [NUM_ENDP*8-1:0]             endPStatusFlat;
  logic [NUM_ENDP*2-1:0]             endPTransTypeFlat;
  logic [NUM_ENDP*2-1:0]             endPNAKTransTypeFlat;
  logic [NUM_ENDP*NAK_CNT_W-1:0]     nakCntFlat;
  logic [NUM_ENDP-1:0]               evtPending;
  logic                              endPInvalid;

  modport master (
    output currEndP, NAKSent, stallSent, CRCError, bitStuffError, RxOverflow,
           RxTimeOut, dataSequence, ACKRxed, transType, transTypeNAK,
           endPMuxErrorsWEn, clrEPRdy, endPCtrlFlat, statusClrEn, statusClrEP,
    input  endPControlReg, clrEPRdyVec, endPStatusFlat, endPTransTypeFlat,
           endPNAKTransTypeFlat, nakCntFlat, evtPending, endPInvalid
  );

  modport slave (
    input  currEndP, NAKSent, stallSent, CRCError, bitStuffError, RxOverflow,
           RxTimeOut, dataSequence, ACKRxed, transType, transTypeNAK,
           endPMuxErrorsWEn, clrEPRdy, endPCtrlFlat, statusClrEn, statusClrEP,
    output endPControlReg, clrEPRdyVec, endPStatusFlat, endPTransTypeFlat,
           endPNAKTransTypeFlat, nakCntFlat, evtPending, endPInvalid
  );

endinterface

// File: rtl/usb_endp_status_slot.sv
// rtl/usb_endp_status_slot.sv - one endpoint's status, transfer types, NAK counter and event flag
module usb_endp_status_slot
  import usb_endp_pkg::*;
#(
  parameter int NAK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic                 nak_i,
  input  logic [STATUS_W-1:0]  status_word_i,
  input  logic [1:0]           trans_type_i,
  input  logic [1:0]           trans_type_nak_i,
  input  logic                 clr_i,
  output logic [STATUS_W-1:0]  status_o,
  output logic [1:0]           trans_type_o,
  output logic [1:0]           nak_trans_type_o,
  output logic [NAK_CNT_W-1:0] nak_cnt_o,
  output logic                 evt_pending_o
);

  logic [STATUS_W-1:0]  status_q, status_d;
  logic [1:0]           tt_q, tt_d;
  logic [1:0]           ntt_q, ntt_d;
  logic [NAK_CNT_W-1:0] nak_cnt_q, nak_cnt_d;
  logic                 evt_q, evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= '0;
      tt_q      <= '0;
      ntt_q     <= '0;
      nak_cnt_q <= '0;
      evt_q     <= 1'b0;
    end else begin
      status_q  <= status_d;
      tt_q      <= tt_d;
      ntt_q     <= ntt_d;
      nak_cnt_q <= nak_cnt_d;
      evt_q     <= evt_d;
    end
  end

  // A write beats a same-cycle host clear so a fresh event is never dropped.
  always_comb begin
    status_d  = status_q;
    tt_d      = tt_q;
    ntt_d     = ntt_q;
    nak_cnt_d = nak_cnt_q;
    evt_d     = evt_q;
    if (wr_en_i) begin
      evt_d = 1'b1;
      if (nak_i) begin
        status_d[STAT_NAK] = 1'b1;
        ntt_d              = trans_type_nak_i;
        if (nak_cnt_q != {NAK_CNT_W{1'b1}}) begin
          nak_cnt_d = nak_cnt_q + NAK_CNT_W'(1);
        end
      end else begin
        status_d  = status_word_i;
        tt_d      = trans_type_i;
        nak_cnt_d = '0;
      end
    end else if (clr_i) begin
      status_d  = '0;
      nak_cnt_d = '0;
      evt_d     = 1'b0;
    end
  end

  assign status_o         = status_q;
  assign trans_type_o     = tt_q;
  assign nak_trans_type_o = ntt_q;
  assign nak_cnt_o        = nak_cnt_q;
  assign evt_pending_o    = evt_q;

endmodule

// File: rtl/usb_endp_status_bank.sv
// rtl/usb_endp_status_bank.sv - endpoint decode, control-word mux, ready-clear routing and per-EP status slots
module usb_endp_status_bank
  import usb_endp_pkg::*;
#(
  parameter int NUM_ENDP  = 4,
  parameter int CTRL_W    = 5,
  parameter int NAK_CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  usb_endp_status_bank_if.slave bus
);

  localparam logic [EP_IDX_W:0] NUM_EP_L = (EP_IDX_W+1)'(NUM_ENDP);

  logic                ep_valid;
  logic [STATUS_W-1:0] status_word;

  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [NUM_ENDP-1:0] clr_vec_q, clr_vec_d;
  logic                invalid_q, invalid_d;

  logic [STATUS_W-1:0]  stat_arr [NUM_ENDP];
  logic [1:0]           tt_arr   [NUM_ENDP];
  logic [1:0]           ntt_arr  [NUM_ENDP];
  logic [NAK_CNT_W-1:0] cnt_arr  [NUM_ENDP];
  logic                 evt_arr  [NUM_ENDP];

  logic [NUM_ENDP*8-1:0]         stat_flat;
  logic [NUM_ENDP*2-1:0]         tt_flat;
  logic [NUM_ENDP*2-1:0]         ntt_flat;
  logic [NUM_ENDP*NAK_CNT_W-1:0] cnt_flat;
  logic [NUM_ENDP-1:0]           evt_vec;

  assign ep_valid    = {1'b0, bus.currEndP} < NUM_EP_L;
  assign status_word = pack_status(bus.dataSequence, bus.ACKRxed, bus.stallSent,
                                   bus.RxTimeOut, bus.RxOverflow,
                                   bus.bitStuffError, bus.CRCError);

  // Decoding against each implemented index leaves the mux at zero for unimplemented endpoints.
  always_comb begin
    ctrl_d    = '0;
    clr_vec_d = '0;
    for (int i = 0; i < NUM_ENDP; i++) begin
      if (bus.currEndP == EP_IDX_W'(i)) begin
        ctrl_d       = bus.endPCtrlFlat[i*CTRL_W +: CTRL_W];
        clr_vec_d[i] = bus.clrEPRdy;
      end
    end
    invalid_d = bus.endPMuxErrorsWEn && !ep_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      clr_vec_q <= '0;
      invalid_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      clr_vec_q <= clr_vec_d;
      invalid_q <= invalid_d;
    end
  end

  for (genvar g = 0; g < NUM_ENDP; g++) begin : g_slot
    usb_endp_status_slot #(
      .NAK_CNT_W (NAK_CNT_W)
    ) u_slot (
      .clk              (clk),
      .rst              (rst),
      .wr_en_i          (bus.endPMuxErrorsWEn && (bus.currEndP == EP_IDX_W'(g))),
      .nak_i            (bus.NAKSent),
      .status_word_i    (status_word),
      .trans_type_i     (bus.transType),
      .trans_type_nak_i (bus.transTypeNAK),
      .clr_i            (bus.statusClrEn && (bus.statusClrEP == EP_IDX_W'(g))),
      .status_o         (stat_arr[g]),
      .trans_type_o     (tt_arr[g]),
      .nak_trans_type_o (ntt_arr[g]),
      .nak_cnt_o        (cnt_arr[g]),
      .evt_pending_o    (evt_arr[g])
    );
  end

  always_comb begin
    stat_flat = '0;
    tt_flat   = '0;
    ntt_flat  = '0;
    cnt_flat  = '0;
    evt_vec   = '0;
    for (int i = 0; i < NUM_ENDP; i++) begin
      stat_flat[i*8 +: 8]                = stat_arr[i];
      tt_flat[i*2 +: 2]                  = tt_arr[i];
      ntt_flat[i*2 +: 2]                 = ntt_arr[i];
      cnt_flat[i*NAK_CNT_W +: NAK_CNT_W] = cnt_arr[i];
      evt_vec[i]                         = evt_arr[i];
    end
  end

  assign bus.endPControlReg       = ctrl_q;
  assign bus.clrEPRdyVec          = clr_vec_q;
  assign bus.endPInvalid          = invalid_q;
  assign bus.endPStatusFlat       = stat_flat;
  assign bus.endPTransTypeFlat    = tt_flat;
  assign bus.endPNAKTransTypeFlat = ntt_flat;
  assign bus.nakCntFlat           = cnt_flat;
  assign bus.evtPending           = evt_vec;

endmodule

// File: tb/tb_usb_endp_status_bank.sv
// tb/tb_usb_endp_status_bank.sv - directed stimulus with a cycle-tagged scoreboard for usb_endp_status_bank
module tb_usb_endp_status_bank;
  import usb_endp_pkg::*;

  localparam int NUM_ENDP  = 4;
  localparam int CTRL_W    = 5;
  localparam int NAK_CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_endp_status_bank_if #(.NUM_ENDP(NUM_ENDP), .CTRL_W(CTRL_W), .NAK_CNT_W(NAK_CNT_W)) bus ();

  usb_endp_status_bank #(
    .NUM_ENDP  (NUM_ENDP),
    .CTRL_W    (CTRL_W),
    .NAK_CNT_W (NAK_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {F_CTRL, F_CLRVEC, F_INV, F_EVT, F_STATUS, F_TT, F_NAKTT, F_NAKCNT} field_e;
  typedef struct {
    int          cyc;
    field_e      f;
    int          ep;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_a;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [CTRL_W-1:0] ctrl_w [NUM_ENDP];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(field_e f);
    case (f)
      F_CTRL:   return "endPControlReg";
      F_CLRVEC: return "clrEPRdyVec";
      F_INV:    return "endPInvalid";
      F_EVT:    return "evtPending";
      F_STATUS: return "status";
      F_TT:     return "transType";
      F_NAKTT:  return "nakTransType";
      default:  return "nakCnt";
    endcase
  endfunction

  function automatic logic [31:0] act(field_e f, int ep);
    case (f)
      F_CTRL:   return 32'(bus.endPControlReg);
      F_CLRVEC: return 32'(bus.clrEPRdyVec);
      F_INV:    return 32'(bus.endPInvalid);
      F_EVT:    return 32'(bus.evtPending);
      F_STATUS: return 32'(bus.endPStatusFlat[ep*8 +: 8]);
      F_TT:     return 32'(bus.endPTransTypeFlat[ep*2 +: 2]);
      F_NAKTT:  return 32'(bus.endPNAKTransTypeFlat[ep*2 +: 2]);
      default:  return 32'(bus.nakCntFlat[ep*NAK_CNT_W +: NAK_CNT_W]);
    endcase
  endfunction

  // Monitor: every falling edge, retire the expectations tagged for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      mon_a = act(mon_e.f, mon_e.ep);
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL stale %s ep%0d: due cycle %0d, now %0d", fname(mon_e.f), mon_e.ep, mon_e.cyc, cyc);
      end else if (mon_a !== mon_e.exp) begin
        errors++;
        $display("FAIL %s ep%0d @cyc %0d: got %0h expected %0h", fname(mon_e.f), mon_e.ep, cyc, mon_a, mon_e.exp);
      end
    end
  end

  task automatic push_exp(int dly, field_e f, int ep, logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.f   = f;
    e.ep  = ep;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push_all_zero();
    push_exp(0, F_CTRL, 0, 0);
    push_exp(0, F_CLRVEC, 0, 0);
    push_exp(0, F_INV, 0, 0);
    push_exp(0, F_EVT, 0, 0);
    for (int e = 0; e < NUM_ENDP; e++) begin
      push_exp(0, F_STATUS, e, 0);
      push_exp(0, F_TT, e, 0);
      push_exp(0, F_NAKTT, e, 0);
      push_exp(0, F_NAKCNT, e, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.currEndP         = '0;
    bus.endPMuxErrorsWEn = 1'b0;
    bus.clrEPRdy         = 1'b0;
    bus.statusClrEn      = 1'b0;
    bus.statusClrEP      = '0;
    bus.transType        = 2'b00;
    bus.transTypeNAK     = 2'b00;
    {bus.dataSequence, bus.ACKRxed, bus.stallSent, bus.NAKSent,
     bus.RxTimeOut, bus.RxOverflow, bus.bitStuffError, bus.CRCError} = 8'h00;
  endtask

  // Flag byte follows the status layout; bit 4 drives NAKSent.
  task automatic drive_write(int ep, logic [7:0] flags, logic [1:0] tt, logic [1:0] ttn);
    idle();
    bus.currEndP         = EP_IDX_W'(ep);
    bus.endPMuxErrorsWEn = 1'b1;
    bus.transType        = tt;
    bus.transTypeNAK     = ttn;
    {bus.dataSequence, bus.ACKRxed, bus.stallSent, bus.NAKSent,
     bus.RxTimeOut, bus.RxOverflow, bus.bitStuffError, bus.CRCError} = flags;
  endtask

  task automatic host_clear(int ep);
    bus.statusClrEn = 1'b1;
    bus.statusClrEP = EP_IDX_W'(ep);
  endtask

  initial begin
    ctrl_w[0] = 5'h11;
    ctrl_w[1] = 5'h0A;
    ctrl_w[2] = 5'h1F;
    ctrl_w[3] = 5'h03;
    bus.endPCtrlFlat = {ctrl_w[3], ctrl_w[2], ctrl_w[1], ctrl_w[0]};
    idle();
    rst = 1'b1;
    tick();
    tick();
    push_all_zero();
    tick();
    rst = 1'b0;
    tick();

    // Reset asserted between edges while writes are in flight
    drive_write(0, 8'h0F, TT_IN, TT_SETUP);
    bus.clrEPRdy = 1'b1;
    push_exp(1, F_STATUS, 0, 32'h0F);
    push_exp(1, F_TT, 0, 32'(TT_IN));
    push_exp(1, F_EVT, 0, 32'h1);
    push_exp(1, F_CLRVEC, 0, 32'h1);
    push_exp(1, F_CTRL, 0, 32'(ctrl_w[0]));
    tick();
    drive_write(1, 8'h10, TT_OUTDATA, TT_IN);
    bus.clrEPRdy = 1'b1;
    tick();
    rst = 1'b1;
    push_all_zero();
    tick();
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Plain write to EP2
    drive_write(2, 8'h81, 2'b01, 2'b11);
    push_exp(1, F_STATUS, 2, 32'h81);
    push_exp(1, F_TT, 2, 32'h1);
    push_exp(1, F_NAKTT, 2, 32'h0);
    push_exp(1, F_NAKCNT, 2, 32'h0);
    push_exp(1, F_EVT, 0, 32'b0100);
    tick();

    // NAK run on EP1 with saturation, then a clean completion
    drive_write(1, 8'h28, TT_OUTDATA, TT_SETUP);
    push_exp(1, F_STATUS, 1, 32'h28);
    push_exp(1, F_TT, 1, 32'(TT_OUTDATA));
    push_exp(1, F_EVT, 0, 32'b0110);
    tick();
    for (int n = 1; n <= 300; n++) begin
      drive_write(1, 8'h11, TT_SETUP, TT_IN);
      push_exp(1, F_NAKCNT, 1, (n > 255) ? 32'd255 : 32'(n));
      tick();
    end
    push_exp(0, F_STATUS, 1, 32'h38);
    push_exp(0, F_NAKTT, 1, 32'(TT_IN));
    push_exp(0, F_TT, 1, 32'(TT_OUTDATA));
    drive_write(1, 8'h40, TT_IN, TT_OUTDATA);
    push_exp(1, F_NAKCNT, 1, 32'h0);
    push_exp(1, F_STATUS, 1, 32'h40);
    push_exp(1, F_TT, 1, 32'(TT_IN));
    push_exp(1, F_NAKTT, 1, 32'(TT_IN));
    tick();

    // Write and host clear in the same cycle
    drive_write(3, 8'h05, TT_OUTDATA, TT_SETUP);
    host_clear(3);
    push_exp(1, F_STATUS, 3, 32'h05);
    push_exp(1, F_TT, 3, 32'(TT_OUTDATA));
    push_exp(1, F_EVT, 0, 32'b1110);
    tick();
    drive_write(3, 8'h10, TT_SETUP, TT_OUTDATA);
    push_exp(1, F_STATUS, 3, 32'h15);
    push_exp(1, F_NAKCNT, 3, 32'h1);
    push_exp(1, F_NAKTT, 3, 32'(TT_OUTDATA));
    tick();
    drive_write(0, 8'h02, TT_IN, TT_SETUP);
    host_clear(3);
    push_exp(1, F_STATUS, 0, 32'h02);
    push_exp(1, F_TT, 0, 32'(TT_IN));
    push_exp(1, F_STATUS, 3, 32'h00);
    push_exp(1, F_NAKCNT, 3, 32'h0);
    push_exp(1, F_TT, 3, 32'(TT_OUTDATA));
    push_exp(1, F_NAKTT, 3, 32'(TT_OUTDATA));
    push_exp(1, F_EVT, 0, 32'b0111);
    tick();
    idle();
    host_clear(9);
    push_exp(1, F_EVT, 0, 32'b0111);
    push_exp(1, F_STATUS, 2, 32'h81);
    tick();
    idle();
    host_clear(2);
    push_exp(1, F_EVT, 0, 32'b0011);
    push_exp(1, F_STATUS, 2, 32'h00);
    push_exp(1, F_TT, 2, 32'h1);
    tick();

    // Write to an unimplemented endpoint
    drive_write(5, 8'hFF, TT_IN, TT_IN);
    bus.clrEPRdy = 1'b1;
    push_exp(1, F_INV, 0, 32'h1);
    push_exp(1, F_CLRVEC, 0, 32'h0);
    push_exp(1, F_CTRL, 0, 32'h0);
    push_exp(1, F_EVT, 0, 32'b0011);
    push_exp(1, F_STATUS, 0, 32'h02);
    push_exp(1, F_STATUS, 1, 32'h40);
    push_exp(1, F_NAKCNT, 1, 32'h0);
    tick();
    idle();
    push_exp(1, F_INV, 0, 32'h0);
    tick();

    // Control mux and ready-clear sweep
    for (int i = 0; i < NUM_ENDP; i++) begin
      idle();
      bus.currEndP = EP_IDX_W'(i);
      bus.clrEPRdy = 1'b1;
      push_exp(1, F_CTRL, 0, 32'(ctrl_w[i]));
      push_exp(1, F_CLRVEC, 0, 32'(1 << i));
      tick();
    end
    idle();
    bus.currEndP = 4'd2;
    push_exp(1, F_CLRVEC, 0, 32'h0);
    push_exp(1, F_CTRL, 0, 32'(ctrl_w[2]));
    tick();
    bus.currEndP = 4'd15;
    bus.clrEPRdy = 1'b1;
    push_exp(1, F_CTRL, 0, 32'h0);
    push_exp(1, F_CLRVEC, 0, 32'h0);
    push_exp(1, F_INV, 0, 32'h0);
    tick();
    idle();

    for (int w = 0; w < 10 && sb.size() > 0; w++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
